// File: rtl/mmio_hex_display_pkg.sv
// mmio_hex_display_pkg: shared addresses, enums and segment encoder for the hex display block
package mmio_hex_display_pkg;
  localparam logic [31:0] HEX_LO_ADDR = 32'h0000_0400;
  localparam logic [31:0] HEX_HI_ADDR = 32'h0000_0404;
  localparam logic [31:0] CTRL_ADDR = 32'h0000_0408;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  typedef enum logic [1:0] {XFER_BYTE, XFER_HALF, XFER_WORD, XFER_RSVD} xfer_size_e;
  typedef enum logic [1:0] {BLANK, FLASH, SHOW} pair_state_e;
  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/mmio_hex_display_pair.sv
// hex_pair_fsm: one digit pair's byte register, blank/flash/show sequencing and registered segment outputs
module hex_pair_fsm
  import mmio_hex_display_pkg::*;
#(
  parameter int FLASH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       blank,
  output logic [6:0] hex_lo,
  output logic [6:0] hex_hi
);
  localparam int CW = FLASH_CYCLES > 1 ? $clog2(FLASH_CYCLES) : 1;
  pair_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] byte_q;
  logic show;
  // a load always (re)starts the flash window, whatever state the pair is in
  always_comb begin
    state_d = load ? FLASH : (state_q == FLASH && cnt_q == '0) ? SHOW : state_q;
    cnt_d = load ? CW'(FLASH_CYCLES - 1) : (state_q == FLASH && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    show = state_q == SHOW && !blank;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BLANK;
      cnt_q <= '0;
      byte_q <= 8'h00;
      hex_lo <= SEG_OFF;
      hex_hi <= SEG_OFF;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (load) byte_q <= data;
      hex_lo <= show ? seg(byte_q[3:0]) : SEG_OFF;
      hex_hi <= show ? seg(byte_q[7:4]) : SEG_OFF;
    end
  end
endmodule

// File: rtl/mmio_hex_display.sv
// mmio_hex_display: snoops MEM-stage stores and drives four 7-segment digits from mapped display registers
module mmio_hex_display
  import mmio_hex_display_pkg::*;
#(
  parameter int FLASH_CYCLES = 4,
  parameter int BLINK_DIV = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [1:0]  xfer_size,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [7:0]  update_cnt
);
  logic store, lo_wr, hi_wr, ctrl_wr, blank;
  logic [1:0] ctrl_q;
  logic [BLINK_DIV-1:0] blink_q;
  logic unused;
  // only the low byte of any store size reaches the display
  assign unused = &{1'b0, write_data[31:8]};
  assign store = write_en && xfer_size_e'(xfer_size) != XFER_RSVD;
  assign lo_wr = store && address == HEX_LO_ADDR;
  assign hi_wr = store && address == HEX_HI_ADDR;
  assign ctrl_wr = store && address == CTRL_ADDR;
  assign blank = ctrl_q[0] || (ctrl_q[1] && blink_q[BLINK_DIV-1]);
  assign HEX4 = SEG_OFF;
  assign HEX5 = SEG_OFF;
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= 2'b00;
      update_cnt <= 8'd0;
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + 1'b1;
      if (ctrl_wr) ctrl_q <= write_data[1:0];
      if (lo_wr || hi_wr || ctrl_wr) update_cnt <= update_cnt + 8'd1;
    end
  end
  hex_pair_fsm #(.FLASH_CYCLES(FLASH_CYCLES)) u_lo (
    .clk(clk), .reset(reset), .load(lo_wr), .data(write_data[7:0]), .blank(blank),
    .hex_lo(HEX0), .hex_hi(HEX1)
  );
  hex_pair_fsm #(.FLASH_CYCLES(FLASH_CYCLES)) u_hi (
    .clk(clk), .reset(reset), .load(hi_wr), .data(write_data[7:0]), .blank(blank),
    .hex_lo(HEX2), .hex_hi(HEX3)
  );
endmodule
